// File: rtl/bicintp_linebuf.sv
// bicintp_linebuf: five-line ring buffer between the CMOS pixel stream and the
// bicubic interpolation engine. Source row r lives in bank r mod 5. The block
// raises cmos_ram_ready once the four-row window around win_row is written, and
// returns the four vertical taps of one column per read, with edge replication.
module bicintp_linebuf #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int DW    = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rstn,
    input  logic          cmos_vsync,
    input  logic          cmos_de,
    input  logic [DW-1:0] cmos_data,
    output logic          cmos_ram_ready,
    input  logic          cmos_ram_rd_enb,
    input  logic [9:0]    cmos_ram_rd_addr,
    input  logic          cmos_ram_rd_sel,
    output logic [DW-1:0] tap_r0,
    output logic [DW-1:0] tap_r1,
    output logic [DW-1:0] tap_r2,
    output logic [DW-1:0] tap_r3,
    output logic          tap_vld,
    output logic          ovf_err,
    input  logic          err_clr
);

    localparam int RW = $clog2(V_ACT + 1);   // row counters reach V_ACT
    localparam int CW = $clog2(H_ACT + 1);   // column counter reaches H_ACT
    localparam int AW = $clog2(H_ACT);       // line RAM address width

    localparam logic [RW-1:0] V_MAX   = RW'(V_ACT);
    localparam logic [RW-1:0] V_LAST  = RW'(V_ACT - 1);
    localparam logic [RW-1:0] V_LAST2 = RW'(V_ACT - 2);
    localparam logic [CW-1:0] H_MAX   = CW'(H_ACT);
    localparam logic [9:0]    H_LAST  = 10'(H_ACT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Ring successor / predecessor of a bank index (0..4).
    function automatic logic [2:0] inc5(input logic [2:0] b);
        return (b == 3'd4) ? 3'd0 : b + 3'd1;
    endfunction

    function automatic logic [2:0] dec5(input logic [2:0] b);
        return (b == 3'd0) ? 3'd4 : b - 3'd1;
    endfunction

    // Increment that stops at a ceiling.
    function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v, input logic [RW-1:0] top);
        return (v >= top) ? top : v + RW'(1);
    endfunction

    state_t        state_q, state_d;
    logic          vsync_q, de_q;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [2:0]    wr_bank_q, wr_bank_d;
    logic [CW-1:0] wr_col_q, wr_col_d;
    logic [RW-1:0] lines_done_q, lines_done_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [2:0]    win_bank_q, win_bank_d;
    logic          ready_q, ready_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] line_mem [0:4][0:H_ACT-1];

    logic          vs_rise, de_fall, wr_en, line_done, ovf_set;
    logic [RW-1:0] win_lo;
    logic [RW:0]   need_rows;
    logic [2:0]    b0, b1, b2, b3;
    logic [9:0]    rd_col;

    // Frame activity: IDLE until the first vsync, then ACTIVE until reset.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Event detection, write/window bookkeeping and next-state logic.
    always_comb begin
        state_d      = state_q;
        wr_row_d     = wr_row_q;
        wr_bank_d    = wr_bank_q;
        wr_col_d     = wr_col_q;
        lines_done_d = lines_done_q;
        win_row_d    = win_row_q;
        win_bank_d   = win_bank_q;

        vs_rise   = cmos_vsync & ~vsync_q;
        de_fall   = ~cmos_de & de_q;
        // A new frame discards whatever line is in progress, so nothing is
        // written or completed in the vsync cycle itself.
        wr_en     = (state_q == ACTIVE) && cmos_de && !vs_rise &&
                    (wr_col_q < H_MAX) && (wr_row_q < V_MAX);
        line_done = (state_q == ACTIVE) && de_fall && !vs_rise &&
                    (wr_col_q != '0) && (wr_row_q < V_MAX);

        // Oldest row the reader may still touch is win_row-1 (clamped at 0).
        win_lo    = (win_row_q == '0) ? '0 : win_row_q - RW'(1);
        ovf_set   = wr_en && (wr_col_q == '0) &&
                    ({1'b0, wr_row_q} >= {1'b0, win_lo} + (RW+1)'(5));
        ovf_d     = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_q);

        need_rows = ({1'b0, win_row_q} + (RW+1)'(3) > (RW+1)'(V_ACT)) ?
                    (RW+1)'(V_ACT) : {1'b0, win_row_q} + (RW+1)'(3);
        ready_d   = (state_q == ACTIVE) && ({1'b0, lines_done_q} >= need_rows);

        if (vs_rise) begin
            state_d      = ACTIVE;
            wr_row_d     = '0;
            wr_bank_d    = '0;
            wr_col_d     = '0;
            lines_done_d = '0;
            win_row_d    = '0;
            win_bank_d   = '0;
        end else begin
            if (wr_en) wr_col_d = wr_col_q + CW'(1);
            if (line_done) begin
                lines_done_d = sat_inc(lines_done_q, V_MAX);
                wr_row_d     = sat_inc(wr_row_q, V_MAX);
                wr_bank_d    = inc5(wr_bank_q);
                wr_col_d     = '0;
            end
            if (cmos_ram_rd_sel && (win_row_q < V_LAST)) begin
                win_row_d  = win_row_q + RW'(1);
                win_bank_d = inc5(win_bank_q);
            end
        end
    end

    // Control and counter registers.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            wr_row_q     <= '0;
            wr_bank_q    <= '0;
            wr_col_q     <= '0;
            lines_done_q <= '0;
            win_row_q    <= '0;
            win_bank_q   <= '0;
            ready_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            vsync_q      <= cmos_vsync;
            de_q         <= cmos_de;
            wr_row_q     <= wr_row_d;
            wr_bank_q    <= wr_bank_d;
            wr_col_q     <= wr_col_d;
            lines_done_q <= lines_done_d;
            win_row_q    <= win_row_d;
            win_bank_q   <= win_bank_d;
            ready_q      <= ready_d;
            ovf_q        <= ovf_d;
        end
    end

    // Tap bank selection with edge replication at the top and bottom rows.
    always_comb begin
        b1     = win_bank_q;
        b0     = (win_row_q == '0) ? b1 : dec5(b1);
        b2     = (win_row_q >= V_LAST) ? b1 : inc5(b1);
        b3     = (win_row_q >= V_LAST2) ? b2 : inc5(b2);
        rd_col = (cmos_ram_rd_addr > H_LAST) ? H_LAST : cmos_ram_rd_addr;
    end

    // Line RAM write port: one pixel per cycle into the current row's bank.
    always_ff @(posedge sys_clk) begin
        if (wr_en) line_mem[wr_bank_q][wr_col_q[AW-1:0]] <= cmos_data;
    end

    // Synchronous four-tap read; taps hold between reads.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tap_r0  <= '0;
            tap_r1  <= '0;
            tap_r2  <= '0;
            tap_r3  <= '0;
            tap_vld <= 1'b0;
        end else begin
            tap_vld <= cmos_ram_rd_enb;
            if (cmos_ram_rd_enb) begin
                tap_r0 <= line_mem[b0][rd_col[AW-1:0]];
                tap_r1 <= line_mem[b1][rd_col[AW-1:0]];
                tap_r2 <= line_mem[b2][rd_col[AW-1:0]];
                tap_r3 <= line_mem[b3][rd_col[AW-1:0]];
            end
        end
    end

    assign cmos_ram_ready = ready_q;
    assign ovf_err        = ovf_q;

endmodule

// File: doc/bicintp_linebuf.md
# bicintp_linebuf

Source line buffer directly upstream of the bicubic interpolation engine. It captures the 640x480 CMOS pixel stream into a five-line ring of line RAMs and tells the engine when the four-row window it needs is complete. On each engine read it returns the four vertical taps (rows n-1..n+2) of one source column, with edge replication at the frame top and bottom. It advances the window one source row per `cmos_ram_rd_sel` pulse.

## Interface
- H_ACT, 640, active pixels per source line
- V_ACT, 480, active source lines per frame
- DW, 8, pixel width
- sys_clk  in  1  system clock
- sys_rstn  in  1  reset, asynchronous, active-low
- cmos_vsync  in  1  frame sync; rising edge = frame start
- cmos_de  in  1  pixel valid, high for the whole active line
- cmos_data  in  DW  pixel data, sampled when cmos_de=1
- cmos_ram_ready  out  1  current read window fully written
- cmos_ram_rd_enb  in  1  read strobe
- cmos_ram_rd_addr  in  10  source column to read
- cmos_ram_rd_sel  in  1  one-cycle pulse: advance window by one source row
- tap_r0..tap_r3  out  DW each  pixels of rows win_row-1, win_row, win_row+1, win_row+2 (clamped)
- tap_vld  out  1  taps valid
- ovf_err  out  1  sticky: writer overran a row still in the window
- err_clr  in  1  clears ovf_err

## Operation
- Storage: 5 banks of H_ACT x DW, synchronous read. Source row r is stored in bank r mod 5.
- Frame start (cmos_vsync 0->1, detected on a registered copy):
  - wr_row=0, wr_col=0, lines_done=0, win_row=0, frame_act=1.
  - Any line in progress is discarded.
- Write side:
  - Each cycle with cmos_de=1 and wr_col<H_ACT: write cmos_data to bank(wr_row)[wr_col], then wr_col+1.
  - Pixels beyond H_ACT in the same DE burst are dropped.
  - On the cmos_de falling edge with wr_col!=0: the line completes. Apply lines_done+1 and wr_row+1, saturating at V_ACT, then wr_col=0.
  - A short line still counts as complete; its unwritten columns are stale.
  - Lines after V_ACT are ignored until the next vsync.
- Ready:
  - cmos_ram_ready = frame_act && lines_done >= min(win_row+3, V_ACT), registered.
- Window advance:
  - On cmos_ram_rd_sel=1: win_row+1, saturating at V_ACT-1.
  - Simultaneous rd_sel and line completion: both apply.
- Tap row clamp: row index k maps to max(0, min(k, V_ACT-1)).
  - win_row=0 gives rows 0,0,1,2.
  - win_row=V_ACT-1 gives rows 478,479,479,479.
- Read:
  - cmos_ram_rd_enb=1 reads all four banks at min(cmos_ram_rd_addr, H_ACT-1).
  - Uses the window value before any rd_sel in the same cycle.
- Overflow:
  - At the start of writing row w (first DE pixel), if w - max(win_row-1,0) >= 5, set ovf_err.
  - The write still proceeds and the data is corrupt.
  - err_clr clears ovf_err; a set in the same cycle wins.
- No state machine beyond frame_act (IDLE=0 / ACTIVE=1). ACTIVE is left only by reset; a new vsync restarts it.

## Timing
- Reset values: cmos_ram_ready=0, tap_r0..r3=0, tap_vld=0, ovf_err=0. Internally frame_act=0 and all counters 0.
- Read latency: 1 cycle. rd_enb at cycle t gives taps and tap_vld=1 at t+1.
  - tap_vld is 0 otherwise.
  - Taps hold their last value when tap_vld=0.
- Ready latency:
  - The DE falling edge at t (DE sampled low) makes ready reflect the new lines_done at t+2.
  - rd_sel at t makes ready reflect the new win_row at t+2.
- Vsync rising edge sampled at t: ready=0 from t+2.
- Reset mid-frame: all state returns to reset values asynchronously. Writing resumes only after the next vsync.
- Throughput: one write and one four-tap read per cycle, simultaneously allowed. Write-to-read collision on the same bank/address cannot occur while ovf_err=0.

## Test plan
- Reset, then frame start with ramp data (pixel = (row*7+col) mod 256), 3 lines written:
  - ready rises 2 cycles after the third DE fall.
  - rd_addr=5 returns r0..r3 = rows 0,0,1,2 = 5,5,12,19, with tap_vld 1 cycle later.
- Pulse rd_sel 476 times with all lines written:
  - win_row=476, rd_addr=639 returns rows 475..478.
  - Further pulses saturate at 479, giving rows 478,479,479,479.
- rd_addr=900 returns column 639 data.
- Line with 700 DE pixels:
  - Only 640 stored, lines_done+1.
  - Next line's column 0 is correct.
- Writer runs 5 lines ahead with win_row=0, starting row 5 -> ovf_err=1. err_clr -> 0 the next cycle.
- Vsync mid-frame:
  - Ready drops within 2 cycles.
  - The new frame's row 0 is readable after 3 new lines.
  - No stale ready.
